// File: rtl/score_display_driver_pkg.sv
// Purpose: shared constants for the score display driver (segment codes, digit counts).
// Latency: n/a (constants only).
// Backpressure: n/a.
package score_display_driver_pkg;

    localparam int NUM_DIGITS   = 8;
    localparam int GROUP_DIGITS = 4;

    // Segment codes are {g,f,e,d,c,b,a}, active-low (0 = segment lit).
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/bcd_seg_decoder.sv
// Purpose: BCD nibble to active-low 7-segment pattern; non-decimal nibbles show a dash.
// Latency: combinational.
// Backpressure: none.
module bcd_seg_decoder
    import score_display_driver_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    // Table lookup; anything above 9 is an illegal BCD digit and gets a dash.
    always_comb begin
        seg_o = SEG_DASH;
        case (nibble_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/score_display_driver.sv
// Purpose: scans live score (digits 3..0) and latched best score (digits 7..4) onto an 8-digit 7-seg display.
// Latency: AN/SEG/DP are registered, one CLK after the scan index changes.
// Backpressure: none; SCORE_BCD is sampled every cycle, GAME_OVER is a level.
module score_display_driver
    import score_display_driver_pkg::*;
#(
    parameter int unsigned SCAN_DIV  = 100000,
    parameter int unsigned BLINK_DIV = 25000000
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [15:0]           SCORE_BCD,
    input  logic                  GAME_OVER,
    output logic [NUM_DIGITS-1:0] AN,
    output logic [6:0]            SEG,
    output logic                  DP
);

    localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int IDX_W   = $clog2(NUM_DIGITS);

    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
    localparam logic [IDX_W-1:0]   DP_IDX     = IDX_W'(GROUP_DIGITS);

    logic [SCAN_W-1:0]     scan_q, scan_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [BLINK_W-1:0]    blink_q, blink_d;
    logic                  blink_on_q, blink_on_d;
    logic [15:0]           best_q, best_d;
    logic                  go_q;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;

    logic [15:0]           grp_dat;
    logic [3:0]            nib;
    logic                  lz_blank;
    logic                  blank;
    logic [6:0]            dec_seg;

    bcd_seg_decoder u_dec (
        .nibble_i (nib),
        .seg_o    (dec_seg)
    );

    // Scan divider and digit index: index steps once per slot and wraps 7 -> 0.
    always_comb begin
        scan_d = scan_q + SCAN_W'(1);
        idx_d  = idx_q;
        if (scan_q == SCAN_LAST) begin
            scan_d = '0;
            idx_d  = idx_q + IDX_W'(1);
        end
    end

    // Blink timer only runs during game over; otherwise parked at count 0, phase ON.
    always_comb begin
        blink_d    = blink_q + BLINK_W'(1);
        blink_on_d = blink_on_q;
        if (!GAME_OVER) begin
            blink_d    = '0;
            blink_on_d = 1'b1;
        end else if (blink_q == BLINK_LAST) begin
            blink_d    = '0;
            blink_on_d = ~blink_on_q;
        end
    end

    // Best score only moves up, and only on the cycle GAME_OVER rises.
    always_comb begin
        best_d = best_q;
        if (GAME_OVER && !go_q && (SCORE_BCD > best_q)) begin
            best_d = SCORE_BCD;
        end
    end

    // Pick the nibble for the current digit and decide leading-zero blanking within its group.
    always_comb begin
        grp_dat  = idx_q[2] ? best_q : SCORE_BCD;
        nib      = grp_dat[3:0];
        lz_blank = 1'b0;
        case (idx_q[1:0])
            2'd0: begin
                nib      = grp_dat[3:0];
                lz_blank = 1'b0;
            end
            2'd1: begin
                nib      = grp_dat[7:4];
                lz_blank = (grp_dat[15:4] == 12'h000);
            end
            2'd2: begin
                nib      = grp_dat[11:8];
                lz_blank = (grp_dat[15:8] == 8'h00);
            end
            default: begin
                nib      = grp_dat[15:12];
                lz_blank = (grp_dat[15:12] == 4'h0);
            end
        endcase
    end

    // Next display outputs: live digits also go dark in the blink OFF phase.
    always_comb begin
        blank = lz_blank || (!idx_q[2] && !blink_on_q);
        an_d  = ~(NUM_DIGITS'(1) << idx_q);
        seg_d = dec_seg;
        dp_d  = (idx_q != DP_IDX);
        if (blank) begin
            an_d  = '1;
            seg_d = SEG_BLANK;
        end
    end

    // State and output registers; synchronous reset wins over every other event.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            scan_q     <= '0;
            idx_q      <= '0;
            blink_q    <= '0;
            blink_on_q <= 1'b1;
            best_q     <= 16'h0000;
            go_q       <= 1'b0;
            an_q       <= '1;
            seg_q      <= SEG_BLANK;
            dp_q       <= 1'b1;
        end else begin
            scan_q     <= scan_d;
            idx_q      <= idx_d;
            blink_q    <= blink_d;
            blink_on_q <= blink_on_d;
            best_q     <= best_d;
            go_q       <= GAME_OVER;
            an_q       <= an_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
        end
    end

    assign AN  = an_q;
    assign SEG = seg_q;
    assign DP  = dp_q;

endmodule

// File: tb/tb_score_display_driver.sv
// Purpose: directed self-checking bench for score_display_driver with SCAN_DIV=4, BLINK_DIV=8.
// Latency: outputs after release edge k show digit (k/4)%8.
// Backpressure: none.
module tb_score_display_driver;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [15:0] SCORE_BCD;
    logic        GAME_OVER;
    logic [7:0]  AN;
    logic [6:0]  SEG;
    logic        DP;

    int checks = 0;
    int errors = 0;
    int k      = -1;
    int m      = 0;

    always #5 CLK = ~CLK;

    score_display_driver #(
        .SCAN_DIV  (4),
        .BLINK_DIV (8)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .SCORE_BCD (SCORE_BCD),
        .GAME_OVER (GAME_OVER),
        .AN        (AN),
        .SEG       (SEG),
        .DP        (DP)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        k++;
    endtask

    // Advance at least one cycle, then until the bench's scan position reaches digit d.
    task automatic goto_digit(input int d);
        int n;
        n = 0;
        step();
        while ((((k >> 2) & 7) != d) && (n < 64)) begin
            step();
            n++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k0;
        int n;
        int d;
        int off;

        // 1: reset state and zero score
        RESET     = 1'b1;
        GAME_OVER = 1'b0;
        SCORE_BCD = 16'h0000;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_an",  AN,  8'hFF);
        chk("rst_seg", SEG, 7'h7F);
        chk("rst_dp",  DP,  1'b1);
        RESET = 1'b0;
        k     = -1;
        goto_digit(0);
        chk("z_d0_an",  AN,  8'hFE);
        chk("z_d0_seg", SEG, 7'h40);
        chk("z_d0_dp",  DP,  1'b1);
        goto_digit(1);
        chk("z_d1_an",  AN,  8'hFF);
        chk("z_d1_dp",  DP,  1'b1);
        goto_digit(2);
        chk("z_d2_an",  AN,  8'hFF);
        goto_digit(3);
        chk("z_d3_an",  AN,  8'hFF);
        goto_digit(4);
        chk("z_d4_an",  AN,  8'hEF);
        chk("z_d4_seg", SEG, 7'h40);
        chk("z_d4_dp",  DP,  1'b0);
        goto_digit(5);
        chk("z_d5_an",  AN,  8'hFF);
        goto_digit(6);
        chk("z_d6_an",  AN,  8'hFF);
        goto_digit(7);
        chk("z_d7_an",  AN,  8'hFF);

        // 2: score 0105, internal zero shown, leading zero blanked, 32-cycle frame
        SCORE_BCD = 16'h0105;
        goto_digit(0);
        chk("s105_d0_an",  AN,  8'hFE);
        chk("s105_d0_seg", SEG, 7'h12);
        goto_digit(1);
        chk("s105_d1_an",  AN,  8'hFD);
        chk("s105_d1_seg", SEG, 7'h40);
        goto_digit(2);
        chk("s105_d2_an",  AN,  8'hFB);
        chk("s105_d2_seg", SEG, 7'h79);
        goto_digit(3);
        chk("s105_d3_an",  AN,  8'hFF);
        n = 0;
        while (AN != 8'hFE && n < 64) begin step(); n++; end
        k0 = k;
        n  = 0;
        while (AN == 8'hFE && n < 64) begin step(); n++; end
        n  = 0;
        while (AN != 8'hFE && n < 64) begin step(); n++; end
        chk("frame_period", k - k0, 32);

        // 3: best score latch on rising edges only, upward only
        SCORE_BCD = 16'h0042;
        GAME_OVER = 1'b1;
        goto_digit(4);
        chk("b42_d4_an",  AN,  8'hEF);
        chk("b42_d4_seg", SEG, 7'h24);
        chk("b42_d4_dp",  DP,  1'b0);
        goto_digit(5);
        chk("b42_d5_an",  AN,  8'hDF);
        chk("b42_d5_seg", SEG, 7'h19);
        goto_digit(6);
        chk("b42_d6_an",  AN,  8'hFF);
        GAME_OVER = 1'b0;
        step();
        SCORE_BCD = 16'h0030;
        GAME_OVER = 1'b1;
        goto_digit(4);
        chk("b30_d4_seg", SEG, 7'h24);
        goto_digit(5);
        chk("b30_d5_seg", SEG, 7'h19);
        SCORE_BCD = 16'h0099;
        goto_digit(4);
        chk("hold_d4_seg", SEG, 7'h24);
        goto_digit(5);
        chk("hold_d5_seg", SEG, 7'h19);

        // 4: blink live digits while game over, best digits steady
        GAME_OVER = 1'b0;
        SCORE_BCD = 16'h0007;
        step();
        n = 0;
        while (((k & 31) != 25) && n < 64) begin step(); n++; end
        GAME_OVER = 1'b1;
        m = k;
        for (int i = 0; i < 64; i++) begin
            step();
            d = (k >> 2) & 7;
            if (d == 0) begin
                off = ((k - 1 - m) >> 3) & 1;
                if (off != 0) begin
                    chk("blink_off_an", AN, 8'hFF);
                end else begin
                    chk("blink_on_an",  AN,  8'hFE);
                    chk("blink_on_seg", SEG, 7'h78);
                end
            end else if (d == 4) begin
                chk("blink_d4_an",  AN,  8'hEF);
                chk("blink_d4_seg", SEG, 7'h24);
            end
        end

        // 5: non-BCD nibble shows a dash
        GAME_OVER = 1'b0;
        SCORE_BCD = 16'h00A3;
        goto_digit(0);
        chk("a3_d0_an",  AN,  8'hFE);
        chk("a3_d0_seg", SEG, 7'h30);
        goto_digit(1);
        chk("a3_d1_an",  AN,  8'hFD);
        chk("a3_d1_seg", SEG, 7'h3F);
        goto_digit(2);
        chk("a3_d2_an",  AN,  8'hFF);

        // boundary: 9999 and immediate wrap to 0000
        SCORE_BCD = 16'h9999;
        goto_digit(3);
        chk("s9999_d3_an",  AN,  8'hF7);
        chk("s9999_d3_seg", SEG, 7'h10);
        goto_digit(0);
        chk("s9999_d0_seg", SEG, 7'h10);
        SCORE_BCD = 16'h0000;
        step();
        chk("wrap_d0_an",  AN,  8'hFE);
        chk("wrap_d0_seg", SEG, 7'h40);
        goto_digit(3);
        chk("wrap_d3_an",  AN,  8'hFF);

        // 6: GAME_OVER edge coinciding with RESET is discarded
        RESET     = 1'b1;
        GAME_OVER = 1'b1;
        SCORE_BCD = 16'h0007;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst2_an", AN, 8'hFF);
        RESET     = 1'b0;
        GAME_OVER = 1'b0;
        k         = -1;
        goto_digit(0);
        chk("rst2_d0_an",  AN,  8'hFE);
        chk("rst2_d0_seg", SEG, 7'h78);
        goto_digit(4);
        chk("rst2_d4_an",  AN,  8'hEF);
        chk("rst2_d4_seg", SEG, 7'h40);
        chk("rst2_d4_dp",  DP,  1'b0);
        goto_digit(5);
        chk("rst2_d5_an",  AN,  8'hFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/score_display_driver.md
Name: score_display_driver

Overview:
- Consumes the 4-digit BCD score from the score counter and drives the board's 8-digit common-anode 7-segment display.
- Digits 3..0 show the live score. Digits 7..4 show the best score, which the block latches when a game ends.
- Time-multiplexes one digit per scan slot, blanks leading zeros, and blinks the live score while the game is over.

Parameters:
- SCAN_DIV, 100000: CLK cycles per digit slot (1 kHz slot rate, 125 Hz full refresh at 100 MHz).
- BLINK_DIV, 25000000: CLK cycles per blink half-period (2 Hz blink at 100 MHz).

Ports:
- CLK  input  1  system clock, 100 MHz.
- RESET  input  1  synchronous, active-high.
- SCORE_BCD  input  16  live score, 4 BCD nibbles, [3:0] = units.
- GAME_OVER  input  1  level; high while the game is stopped/paused.
- AN  output  8  digit enables, active-low, AN[0] = rightmost digit.
- SEG  output  7  segments {g,f,e,d,c,b,a}, active-low.
- DP  output  1  decimal point, active-low.

Behaviour:
- Reset (RESET sampled on a CLK edge):
  - AN=8'hFF, SEG=7'h7F, DP=1.
  - Scan divider=0, digit index=0, blink counter=0, blink phase=ON, best=16'h0000.
  - GAME_OVER edge register=0.
  - RESET overrides every simultaneous event.
- Scan:
  - Divider counts 0..SCAN_DIV-1.
  - At terminal count, the divider wraps to 0 and the index advances 0->1->...->7->0.
- Output timing:
  - AN, SEG and DP are registered from the current index and data. They update one cycle after the index changes.
  - Exactly one AN bit is low at a time, except when the selected digit is blanked, in which case AN=8'hFF.
- Digit data:
  - Index 0..3 selects SCORE_BCD nibble 0..3.
  - Index 4..7 selects best nibble 0..3.
  - SCORE_BCD is sampled every cycle with no latching, so a change shows at the next visit of that digit.
- Decode:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Nibble >9 shows a dash, 0111111.
- Leading-zero blanking, applied per 4-digit group:
  - Digit k of a group is blanked when it and all higher digits in that group are 0.
  - Group digit 0 is never blanked, so a zero score displays "0".
- DP: 0 only while index=4 (separator between best and live); 1 otherwise.
- Best score:
  - GAME_OVER passes through a one-cycle edge register.
  - On the cycle its rising edge is detected, if SCORE_BCD > best (16-bit unsigned compare, valid for legal BCD), then best <= SCORE_BCD.
  - Equal or lower scores leave best unchanged.
  - Holding GAME_OVER high causes no further updates; the next update needs a fresh rising edge.
- Blink:
  - While GAME_OVER=1, the blink counter runs 0..BLINK_DIV-1 and toggles the phase at terminal count.
  - During the OFF phase, digits 0..3 are forced blank (AN=8'hFF when one is selected).
  - Digits 4..7 never blink.
  - While GAME_OVER=0, the counter is held at 0 and the phase at ON.
- Boundaries:
  - SCORE_BCD=16'h9999 displays 9999; the wrap back to 0000 displays immediately.
  - A GAME_OVER rising edge in the same cycle as RESET is discarded.
  - SCAN_DIV=1 is legal: the index advances every cycle.

Decomposition:
- Shared package/header:
  - segment code constants SEG_0..SEG_9, SEG_DASH, SEG_BLANK;
  - NUM_DIGITS=8, GROUP_DIGITS=4.
- Sub-module bcd_seg_decoder: combinational, 4-bit nibble in, 7-bit active-low segments out, dash for >9.
- The scan, blink and best-score logic stay in score_display_driver.

Test Plan (SCAN_DIV=4, BLINK_DIV=8):
1. RESET held for 3 cycles, then released with SCORE_BCD=0 -> AN=FF, SEG=7F, DP=1 during reset. After release, the index visits digits 0..7. AN[0]=0 with SEG=1000000, AN[4]=0 with SEG=1000000 and DP=0, and digits 1-3 and 5-7 give AN=FF.
2. SCORE_BCD=16'h0105 -> digit0 SEG=0010010, digit1 SEG=1000000, digit2 SEG=1111001, digit3 blanked (AN=FF); full cycle period 32 CLK.
3. SCORE_BCD=16'h0042, GAME_OVER rises -> best=0042, so digit4 shows 2 and digit5 shows 4. GAME_OVER falls, SCORE_BCD=16'h0030, GAME_OVER rises again -> best stays 0042.
4. GAME_OVER held high with SCORE_BCD=16'h0007 -> digit0 alternates between shown and AN=FF every 8 CLK, while digit4 is continuously shown.
5. SCORE_BCD=16'h00A3 -> digit1 SEG=0111111 (dash) and digit0 SEG=0110000.
6. GAME_OVER rises in the same cycle that RESET=1 -> best remains 0000 and the blink phase is ON after reset.
